// File: rtl/threshold_sequencer.sv
// Frame sequencer for the pixel threshold comparator: streams one frame of pixels
// through the comparator, tracks its latency with a valid pipe and counts hits.
module threshold_sequencer #(
    parameter int unsigned PIXELS_PER_FRAME = 64,
    parameter int unsigned CMP_LATENCY      = 1,
    parameter int unsigned CNT_W            = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic             pix_valid,
    output logic             pix_ready,
    input  logic [7:0]       pix_data,
    output logic [7:0]       cmp_in,
    output logic             cmp_enb,
    input  logic             cmp_u,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             res_bit,
    output logic             res_last,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] hit_count
);

    localparam int unsigned     CW        = $clog2(PIXELS_PER_FRAME + 1);
    localparam logic [CW-1:0]   FRAME_LEN = CW'(PIXELS_PER_FRAME);
    localparam logic [CW-1:0]   LAST_IDX  = CW'(PIXELS_PER_FRAME - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t                 state_q, state_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic [CMP_LATENCY-1:0] vpipe_q, vpipe_d;
    logic [CW-1:0]          issued_q, issued_d;
    logic [CW-1:0]          received_q, received_d;
    logic [CNT_W-1:0]       hit_q, hit_d;

    logic advance;
    logic pix_fire;
    logic res_fire;

    assign cmp_in    = pix_data;
    assign res_bit   = cmp_u;
    assign busy      = busy_q;
    assign done      = done_q;
    assign hit_count = hit_q;
    assign res_valid = vpipe_q[CMP_LATENCY-1];

    always_comb begin
        advance   = busy_q & (res_ready | ~res_valid);
        cmp_enb   = advance;
        pix_ready = (state_q == RUN) & advance & (issued_q < FRAME_LEN);
        pix_fire  = pix_valid & pix_ready;
        res_fire  = busy_q & res_valid & res_ready;
        res_last  = busy_q & res_valid & (received_q == LAST_IDX);

        state_d    = state_q;
        vpipe_d    = vpipe_q;
        issued_d   = issued_q;
        received_d = received_q;
        hit_d      = hit_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = RUN;
                    issued_d   = '0;
                    received_d = '0;
                    hit_d      = '0;
                end
            end
            RUN: begin
                if (pix_fire) begin
                    issued_d = issued_q + CW'(1);
                    if (issued_d == FRAME_LEN) state_d = DRAIN;
                end
            end
            DRAIN: ;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // pix_fire is always 0 in DRAIN, so the pipe drains with zeros
        if (advance) vpipe_d = (vpipe_q << 1) | CMP_LATENCY'(pix_fire);

        if (res_fire) begin
            received_d = received_q + CW'(1);
            if (cmp_u && (hit_q != '1)) hit_d = hit_q + CNT_W'(1);
            if (received_q == LAST_IDX) state_d = DONE;
        end

        // abort wins over every transition and discards any result on this edge
        if (abort) begin
            state_d    = IDLE;
            vpipe_d    = '0;
            issued_d   = issued_q;
            received_d = received_q;
            hit_d      = hit_q;
        end

        busy_d = (state_d == RUN) || (state_d == DRAIN);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            vpipe_q    <= '0;
            issued_q   <= '0;
            received_q <= '0;
            hit_q      <= '0;
        end else begin
            state_q    <= state_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            vpipe_q    <= vpipe_d;
            issued_q   <= issued_d;
            received_q <= received_d;
            hit_q      <= hit_d;
        end
    end

endmodule

// File: tb/tb_threshold_sequencer.sv
// Randomized bench for threshold_sequencer, checked cycle by cycle against a
// frame-level reference model plus a per-frame scoreboard.
module tb_threshold_sequencer;

    localparam int unsigned P    = 5;
    localparam int unsigned CW_H = 2;
    localparam int unsigned HMAX = (1 << CW_H) - 1;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_DRAIN = 2;
    localparam int M_DONE  = 3;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            start = 1'b0;
    logic            abort = 1'b0;
    logic            pix_valid = 1'b0;
    logic            pix_ready;
    logic [7:0]      pix_data = 8'd0;
    logic [7:0]      cmp_in;
    logic            cmp_enb;
    logic            cmp_u;
    logic            res_valid;
    logic            res_ready = 1'b0;
    logic            res_bit;
    logic            res_last;
    logic            busy;
    logic            done;
    logic [CW_H-1:0] hit_count;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model
    int m_state    = M_IDLE;
    int m_issued   = 0;
    int m_received = 0;
    int m_hits     = 0;
    bit m_slot_v   = 0;
    bit m_slot_b   = 0;
    int frame_hit_px  = 0;
    int dut_frame_res = 0;

    always #5 clk = ~clk;

    // comparator stand-in with one enabled stage: u = (In1 > 8)
    logic cmp_u_q = 1'b0;
    always_ff @(posedge clk) if (cmp_enb) cmp_u_q <= (cmp_in > 8'd8);
    assign cmp_u = cmp_u_q;

    threshold_sequencer #(
        .PIXELS_PER_FRAME(P),
        .CMP_LATENCY     (1),
        .CNT_W           (CW_H)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .abort    (abort),
        .pix_valid(pix_valid),
        .pix_ready(pix_ready),
        .pix_data (pix_data),
        .cmp_in   (cmp_in),
        .cmp_enb  (cmp_enb),
        .cmp_u    (cmp_u),
        .res_valid(res_valid),
        .res_ready(res_ready),
        .res_bit  (res_bit),
        .res_last (res_last),
        .busy     (busy),
        .done     (done),
        .hit_count(hit_count)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = M_IDLE; m_issued = 0; m_received = 0; m_hits = 0;
        m_slot_v = 0; m_slot_b = 0; frame_hit_px = 0; dut_frame_res = 0;
    endtask

    // one clock cycle: drive inputs after the edge, check mid-cycle, then step
    // the model to where the next edge should leave the block
    task automatic tick(input logic st, input logic ab, input logic pv, input logic rr,
                        input logic [7:0] pd, output logic fired);
        bit e_busy, e_rv, e_adv, e_prdy, e_last, e_done, acc;
        int nxt;
        @(posedge clk); #1;
        start = st; abort = ab; pix_valid = pv; res_ready = rr; pix_data = pd;
        #4;
        e_busy = (m_state == M_RUN) || (m_state == M_DRAIN);
        e_rv   = m_slot_v;
        e_adv  = e_busy && (rr || !e_rv);
        e_prdy = (m_state == M_RUN) && e_adv && (m_issued < P);
        e_last = e_busy && e_rv && (m_received == P - 1);
        e_done = (m_state == M_DONE);

        check_eq("busy", busy, e_busy);
        check_eq("res_valid", res_valid, e_rv);
        check_eq("cmp_enb", cmp_enb, e_adv);
        check_eq("pix_ready", pix_ready, e_prdy);
        check_eq("res_last", res_last, e_last);
        check_eq("done", done, e_done);
        check_eq("hit_count", hit_count, m_hits);
        check_eq("cmp_in", cmp_in, pd);
        if (e_rv) check_eq("res_bit", res_bit, m_slot_b);

        if (res_valid && res_ready && busy) dut_frame_res++;
        if (e_done) begin
            check_eq("frame_results", dut_frame_res, P);
            check_eq("frame_hits", hit_count, (frame_hit_px > HMAX) ? HMAX : frame_hit_px);
        end

        fired = pv && e_prdy;
        acc   = e_rv && rr && e_busy;
        if (ab) begin
            m_state  = M_IDLE;
            m_slot_v = 0;
        end else begin
            nxt = m_state;
            case (m_state)
                M_IDLE: if (st) begin
                    nxt = M_RUN; m_hits = 0; m_issued = 0; m_received = 0;
                    frame_hit_px = 0; dut_frame_res = 0;
                end
                M_RUN: if (fired) begin
                    m_issued++;
                    if (pd > 8) frame_hit_px++;
                    if (m_issued == P) nxt = M_DRAIN;
                end
                M_DONE: nxt = M_IDLE;
                default: ;
            endcase
            if (acc) begin
                if (m_slot_b && m_hits < HMAX) m_hits++;
                if (m_received == P - 1) nxt = M_DONE;
                m_received++;
            end
            if (e_adv) begin
                m_slot_v = fired;
                m_slot_b = (pd > 8);
            end
            m_state = nxt;
        end
    endtask

    // start a frame from the given pixel list; bp_at >= 0 stalls results for 3 cycles
    task automatic directed_frame(input logic [7:0] px[], input int ncyc, input bit toggle,
                                  input int bp_at);
        logic f;
        int idx = 0;
        tick(1, 0, 0, 1, 8'd0, f);
        for (int c = 0; c < ncyc; c++) begin
            logic pv, rr;
            logic [7:0] d;
            pv = toggle ? ((c % 2) == 0) : 1'b1;
            rr = !(bp_at >= 0 && c >= bp_at && c < bp_at + 3);
            d  = (idx < px.size()) ? px[idx] : 8'($urandom);
            if (idx >= px.size()) pv = 1'b0;
            tick(0, 0, pv, rr, d, f);
            if (f) idx++;
        end
    endtask

    initial begin
        logic f;
        logic [7:0] basic[] = '{8'd3, 8'd10, 8'd200, 8'd7, 8'd50};
        logic [7:0] over[]  = '{8'd9, 8'd1, 8'd255, 8'd8, 8'd100, 8'd77, 8'd12};
        logic [7:0] allhi[] = '{8'd9, 8'd20, 8'd30, 8'd40, 8'd250};

        model_reset();
        #22;
        check_eq("rst_busy", busy, 0);
        check_eq("rst_res_valid", res_valid, 0);
        check_eq("rst_pix_ready", pix_ready, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_hit_count", hit_count, 0);
        #1 reset = 1'b1;

        directed_frame(basic, 12, 0, -1);
        directed_frame(basic, 16, 0, 2);
        directed_frame(over, 20, 1, -1);
        directed_frame(allhi, 12, 0, -1);

        // start pulses during RUN must be ignored
        tick(1, 0, 0, 1, 8'd0, f);
        for (int c = 0; c < 10; c++) tick(1, 0, 1, 1, 8'd15, f);

        // abort after two accepted pixels, then a clean frame
        tick(1, 0, 0, 1, 8'd0, f);
        tick(0, 0, 1, 1, 8'd10, f);
        tick(0, 0, 1, 1, 8'd20, f);
        tick(0, 1, 1, 1, 8'd30, f);
        for (int c = 0; c < 3; c++) tick(0, 0, 1, 1, 8'd40, f);
        directed_frame(basic, 12, 0, -1);

        // asynchronous reset between edges in the middle of a frame
        tick(1, 0, 0, 1, 8'd0, f);
        for (int c = 0; c < 3; c++) tick(0, 0, 1, 1, 8'd200, f);
        #2 reset = 1'b0;
        #1;
        check_eq("async_busy", busy, 0);
        check_eq("async_res_valid", res_valid, 0);
        check_eq("async_hit_count", hit_count, 0);
        check_eq("async_done", done, 0);
        model_reset();
        #5 reset = 1'b1;
        for (int c = 0; c < 4; c++) tick(0, 0, 1, 1, 8'd99, f);

        // randomized traffic with occasional starts and aborts
        for (int c = 0; c < 4000; c++) begin
            logic st, ab, pv, rr;
            int mode = (c / 500) % 4;
            st = ($urandom_range(0, 5) == 0);
            ab = ($urandom_range(0, 99) < 2);
            pv = (mode == 0) ? 1'b1 : ($urandom_range(0, 99) < 65);
            rr = (mode == 0) ? 1'b1 : ($urandom_range(0, 99) < ((mode == 3) ? 30 : 70));
            tick(st, ab, pv, rr, 8'($urandom_range(0, 20)), f);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/threshold_sequencer.md
# threshold_sequencer

Frame-level controller for the pixel threshold comparator. On `start` it streams exactly `PIXELS_PER_FRAME` 8-bit pixels from an upstream valid/ready source into the comparator, steps the comparator with its clock enable, and tracks results through the comparator's fixed pipeline latency. It also stalls the comparator on downstream backpressure, forwards one result bit per pixel, and reports a per-frame hit count with a one-cycle `done` pulse. It sits between the pixel source and the edge-map writer.

## Interface
Parameters:
- `PIXELS_PER_FRAME`, 64: pixels per frame; must be at least 1.
- `CMP_LATENCY`, 1: comparator cycles from an `enb`-qualified input to a valid `u`; must be at least 1.
- `CNT_W`, 16: width of `hit_count`.

Ports:
- `clk` input 1: single clock; all logic is rising-edge.
- `reset` input 1: asynchronous, active-low; low forces the reset state immediately.
- `start` input 1: begin a frame; sampled only in IDLE.
- `abort` input 1: synchronous; returns to IDLE from any state, flushes in-flight results and produces no `done`.
- `pix_valid` input 1: upstream pixel valid.
- `pix_ready` output 1: pixel accepted on a clock edge where `pix_valid` and `pix_ready` are both high.
- `pix_data` input 8: pixel value.
- `cmp_in` output 8: comparator input; combinationally equal to `pix_data`.
- `cmp_enb` output 1: comparator clock enable.
- `cmp_u` input 1: comparator result.
- `res_valid` output 1: result valid.
- `res_ready` input 1: downstream ready.
- `res_bit` output 1: equal to `cmp_u`.
- `res_last` output 1: high with the frame's final result.
- `busy` output 1: high in RUN or DRAIN.
- `done` output 1: one-cycle pulse at frame completion.
- `hit_count` output CNT_W: number of accepted results with `res_bit` = 1 in the current or last frame.

## Operation
- States: IDLE, RUN, DRAIN, DONE. Reset state is IDLE.
- Reset values: `pix_ready`, `cmp_enb`, `res_valid`, `res_last`, `busy`, `done` are 0; `hit_count` is 0; issue/result counters are 0; `vpipe` is cleared.
- Definitions:
  - `vpipe[CMP_LATENCY-1:0]` is the in-flight valid shift register.
  - `res_valid` = `vpipe[CMP_LATENCY-1]`.
  - `advance` = busy & (`res_ready` | ~`res_valid`).
  - `cmp_enb` = `advance`.
- IDLE:
  - `pix_ready` = 0.
  - `start` moves to RUN and clears `hit_count`, `issued` and `received` in the same edge.
- RUN:
  - `pix_ready` = `advance` & (`issued` < `PIXELS_PER_FRAME`).
  - Each pixel handshake increments `issued`.
  - On `advance`, `vpipe` shifts in (`pix_valid` & `pix_ready`). When `advance` is low, `vpipe` holds.
  - When `issued` reaches `PIXELS_PER_FRAME`, move to DRAIN.
- DRAIN:
  - `pix_ready` = 0.
  - `vpipe` keeps advancing, shifting in 0s.
- Result acceptance (RUN or DRAIN): a result is accepted on a clock edge where `res_valid` and `res_ready` are both high. Each acceptance increments `received`, and increments `hit_count` when `res_bit` is 1.
  - `hit_count` saturates at 2^CNT_W − 1.
- Frame end: the acceptance with `received` = `PIXELS_PER_FRAME` − 1 moves to DONE. `res_last` is high for exactly that result.
- DONE:
  - `done` = 1 for one cycle; `busy` = 0.
  - Next state is IDLE unconditionally; `start` is ignored in DONE.
- `hit_count` holds its value after DONE until the next accepted `start`.
- `start` is ignored outside IDLE.
- `abort` has priority over all transitions:
  - Next state IDLE; `vpipe` is cleared.
  - `hit_count` holds its partial value; `done` is not asserted.
- Counter widths: `issued` and `received` are clog2(`PIXELS_PER_FRAME`+1) bits.

## Timing
- Latency with `CMP_LATENCY` = 1 and no backpressure:
  - A pixel accepted at edge k produces `res_valid` = 1 during cycle k+1.
  - `res_bit` reflects that pixel.
- Throughput: one pixel per cycle when `pix_valid` and `res_ready` stay high.
- Frame timing, no stalls:
  - Frame duration is `PIXELS_PER_FRAME` + `CMP_LATENCY` cycles from the first accept to DONE.
  - `done` is asserted the cycle after the last result is accepted.
- Backpressure (`res_valid` & ~`res_ready`):
  - `cmp_enb` and `pix_ready` drop in the same cycle.
  - `vpipe` and the comparator pipeline freeze.
  - `res_bit` is stable until accepted; no result is lost or duplicated.
- Upstream bubbles: `pix_valid` low inserts 0 into `vpipe`, giving a gap in `res_valid` after `CMP_LATENCY` advancing cycles.
- Reset mid-frame: all outputs go to their reset values immediately, without waiting for a clock edge. After release, the block is in IDLE and needs a new `start`.
- `PIXELS_PER_FRAME` = 1: RUN lasts one accept, and `res_last` is high with the only result.

## Test plan
- Basic frame: `PIXELS_PER_FRAME`=4; bench comparator u = (In1 > 8); pixels 3, 10, 200, 7 with `res_ready`=1 → results 0, 1, 1, 0; `res_last` on the 4th result; `done` pulse one cycle later; `hit_count`=2.
- Backpressure: same frame with `res_ready` low for 3 cycles while result 2 is valid → `res_bit` held at 1, `cmp_enb`=0 and `pix_ready`=0 during the stall; final `hit_count`=2; exactly 4 results.
- Bubbles and overrun: `pix_valid` toggles 1,0,1,0 and upstream offers 6 pixels → only 4 are accepted, `pix_ready`=0 in DRAIN; no extra results.
- Abort: abort after 2 accepts with values 10 and 20 → IDLE next cycle, `res_valid`=0, no `done`, `hit_count` retains its partial value; a new `start` gives a clean full frame.
- Start while busy and saturation: `start` pulses during RUN are ignored. With `CNT_W`=2 and 5 pixels all >8 (`PIXELS_PER_FRAME`=5), `hit_count`=3.
- Asynchronous reset: drive `reset` low between clock edges mid-frame → `busy`, `res_valid` and `hit_count` read 0 before the next edge; IDLE after release.
